// File: rtl/survivor_if.sv
// survivor_if: operand/result bundle between a requester and survivor_ctrl.
//   start          request to begin a run (requester -> controller)
//   a1..a4         operands captured when start is accepted
//   busy           controller is running (CHECK/STEP/DONE)
//   done           one-cycle completion pulse
//   valid          run ended with exactly one survivor
//   idx            survivor index (a1=0 .. a4=3)
//   winner_val     remaining value of the survivor
//   steps          number of STEP cycles in the run
interface survivor_if #(parameter int W = 5);
    logic         start;
    logic [W-1:0] a1;
    logic [W-1:0] a2;
    logic [W-1:0] a3;
    logic [W-1:0] a4;
    logic         busy;
    logic         done;
    logic         valid;
    logic [1:0]   idx;
    logic [W-1:0] winner_val;
    logic [W-1:0] steps;

    modport master (
        output start, a1, a2, a3, a4,
        input  busy, done, valid, idx, winner_val, steps
    );

    modport slave (
        input  start, a1, a2, a3, a4,
        output busy, done, valid, idx, winner_val, steps
    );
endinterface

// File: rtl/survivor_ctrl.sv
// survivor_ctrl: loads four operands and decrements every nonzero one per
// STEP until at most one remains nonzero, then reports the survivor.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    survivor_if slave: start/a1..a4 in, busy/done/results out
//
// state | meaning
// IDLE  | waiting for start; results hold their last latched values
// CHECK | count nonzero operands, pick STEP or DONE
// STEP  | decrement nonzero operands, bump step counter
// DONE  | latch steps; done pulses on the edge that returns to IDLE
module survivor_ctrl #(
    parameter int W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    survivor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, STEP, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] r [4];
    logic [W-1:0] cnt;
    logic [2:0]   n;
    logic [1:0]   sel;
    logic         busy;
    logic         done_q;
    logic         valid_q;
    logic [1:0]   idx_q;
    logic [W-1:0] win_q;
    logic [W-1:0] steps_q;

    // Nonzero count; sel ends on the last nonzero register, which is the
    // only one whenever n == 1.
    always_comb begin
        n   = '0;
        sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (r[i] != '0) begin
                n   = n + 3'd1;
                sel = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = CHECK;
            CHECK: state_nxt = (n >= 3'd2) ? STEP : DONE;
            STEP:  state_nxt = CHECK;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r[i] <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            win_q   <= '0;
            steps_q <= '0;
        end else begin
            // done is registered off DONE so it appears on the edge that
            // leaves DONE, giving 2+2k edges from start acceptance.
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r[0] <= bus.a1;
                        r[1] <= bus.a2;
                        r[2] <= bus.a3;
                        r[3] <= bus.a4;
                        cnt  <= '0;
                    end
                end
                CHECK: begin
                    if (n == 3'd1) begin
                        valid_q <= 1'b1;
                        idx_q   <= sel;
                        win_q   <= r[sel];
                    end else if (n == 3'd0) begin
                        valid_q <= 1'b0;
                        idx_q   <= '0;
                        win_q   <= '0;
                    end
                end
                STEP: begin
                    for (int i = 0; i < 4; i++) begin
                        if (r[i] != '0) r[i] <= r[i] - 1'b1;
                    end
                    if (cnt != '1) cnt <= cnt + 1'b1;
                end
                DONE: steps_q <= cnt;
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.valid      = valid_q;
    assign bus.idx        = idx_q;
    assign bus.winner_val = win_q;
    assign bus.steps      = steps_q;
endmodule

// File: tb/tb_survivor_ctrl.sv
module tb_survivor_ctrl;
    localparam int W = 5;

    typedef struct {
        logic         v;
        logic [1:0]   idx;
        logic [W-1:0] win;
        logic [W-1:0] steps;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    survivor_if #(.W(W)) bus ();
    survivor_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("valid", 32'(bus.valid), 32'(e.v));
                chk("idx", 32'(bus.idx), 32'(e.idx));
                chk("winner_val", 32'(bus.winner_val), 32'(e.win));
                chk("steps", 32'(bus.steps), 32'(e.steps));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive start on a negedge; the following posedge accepts it, and done
    // must be visible 2+2k edges after that.
    task automatic run(input logic [W-1:0] x1, x2, x3, x4,
                       input logic ev, input logic [1:0] eidx,
                       input logic [W-1:0] ewin, esteps,
                       input int k, input bit repulse);
        exp_t e;
        int   n;
        bus.a1 = x1; bus.a2 = x2; bus.a3 = x3; bus.a4 = x4;
        bus.start = 1'b1;
        e.v = ev; e.idx = eidx; e.win = ewin; e.steps = esteps;
        e.cyc = cyc + 3 + 2 * k;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_in_run", 32'(bus.busy), 1);
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            if (repulse && n == 5) begin
                bus.start = 1'b1;
                bus.a1 = 1; bus.a2 = 0; bus.a3 = 0; bus.a4 = 0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end else begin
            chk("busy_at_done", 32'(bus.busy), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a1 = 0; bus.a2 = 0; bus.a3 = 0; bus.a4 = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_outputs", {bus.valid, bus.idx, bus.winner_val, bus.steps}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 0, 7, 0, 1, 2, 7, 0, 0, 0);
        run(3, 1, 0, 0, 1, 0, 2, 1, 1, 0);
        run(5, 5, 2, 0, 0, 0, 0, 5, 5, 0);
        // Back-to-back: second start lands in the cycle done is high.
        run(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(4, 0, 0, 0, 1, 0, 4, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("hold_valid", 32'(bus.valid), 1);
        chk("hold_winner", 32'(bus.winner_val), 4);
        chk("idle_busy", 32'(bus.busy), 0);

        run(31, 30, 0, 0, 1, 0, 1, 30, 30, 1);
        run(0, 0, 0, 6, 1, 3, 6, 0, 0, 0);
        run(2, 7, 4, 0, 1, 1, 3, 4, 4, 0);

        // Reset while in STEP.
        @(negedge clk);
        bus.a1 = 3; bus.a2 = 3; bus.a3 = 0; bus.a4 = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", 32'(bus.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_rst_busy", 32'(bus.busy), 0);
        chk("midrun_rst_done", 32'(bus.done), 0);
        chk("midrun_rst_outputs", {bus.valid, bus.idx, bus.winner_val, bus.steps}, 0);
        run(0, 9, 0, 0, 1, 1, 9, 0, 0, 0);
        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/survivor_ctrl.md
SURVIVOR_CTRL -- requirements
Module: survivor_ctrl

Interface
REQ-001 Parameter: W, default 5, operand and counter width in bits; legal range 2..8.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request to load the operands and begin a run; sampled only in IDLE.
REQ-005 Port: a1, a2, a3, a4  input  W each  operands, sampled on the edge that accepts start.
REQ-006 Port: busy  output  1  high while a run is in progress (any state other than IDLE).
REQ-007 Port: done  output  1  one-cycle pulse marking result completion.
REQ-008 Port: valid  output  1  high when the finished run produced exactly one survivor.
REQ-009 Port: idx  output  2  survivor index: a1=0, a2=1, a3=2, a4=3.
REQ-010 Port: winner_val  output  W  remaining value of the survivor.
REQ-011 Port: steps  output  W  number of STEP cycles executed in the run.

Function
REQ-012 The FSM shall have exactly four states: IDLE, CHECK, STEP and DONE.
REQ-013 In IDLE with start=1, the block shall load r1..r4 from a1..a4, clear the step counter and enter CHECK on the same edge.
REQ-014 In IDLE with start=0, the block shall hold all state and outputs.
REQ-015 In CHECK, the block shall count the nonzero registers (n), evaluated combinationally from r1..r4.
REQ-016 From CHECK with n=1, the block shall enter DONE and latch valid=1, idx=index of the nonzero register and winner_val=its value.
REQ-017 From CHECK with n=0, the block shall enter DONE and latch valid=0, idx=0 and winner_val=0.
REQ-018 From CHECK with n>=2, the block shall enter STEP.
REQ-019 In STEP, every nonzero register shall decrement by 1, zero registers shall stay 0 (no wrap-around), the step counter shall increment, and the FSM shall return to CHECK.
REQ-020 The step counter shall saturate at 2^W-1 (this is unreachable for legal operands, since all reach 0 within 2^W-1 steps).
REQ-021 In DONE, done shall be 1 for exactly one cycle, steps shall be latched, and the FSM shall return to IDLE.
REQ-022 valid, idx, winner_val and steps shall hold their latched values until the next DONE or reset.
REQ-023 start shall be ignored whenever busy=1; no queuing.
REQ-024 start asserted in the cycle right after DONE (FSM in IDLE) shall be accepted normally.
REQ-025 Latency: with k STEP cycles, done shall assert 2+2k clock edges after the edge accepting start (CHECK and DONE contribute 1 cycle each; each STEP/CHECK pair contributes 2).
REQ-026 Ties: when the last two or more nonzero registers reach 0 in the same STEP, the run shall end with valid=0 (the n=0 rule).
REQ-027 busy shall be 1 in CHECK, STEP and DONE, and 0 in IDLE.

Reset
REQ-028 On a rising edge with rst_n=0, the block shall set the FSM to IDLE and clear r1..r4, the step counter, busy, done, valid, idx, winner_val and steps to 0.
REQ-029 Reset during CHECK, STEP or DONE shall abort the run with no done pulse, and the block shall accept start on the first edge after rst_n returns to 1.
REQ-030 rst_n shall take priority over start on the same edge.

Verification
REQ-031 Scenario: a=(0,0,7,0), start pulse -> done 2 edges later; valid=1, idx=2, winner_val=7, steps=0.
REQ-032 Scenario: a=(3,1,0,0) -> one STEP; done at edge 4; valid=1, idx=0, winner_val=2, steps=1.
REQ-033 Scenario: a=(5,5,2,0) -> tie after 5 STEPs; done at edge 12; valid=0, idx=0, winner_val=0, steps=5.
REQ-034 Scenario: a=(0,0,0,0) -> done at edge 2; valid=0, steps=0; a second start on the following cycle is accepted.
REQ-035 Scenario: a=(31,30,0,0) with start re-pulsed mid-run -> the re-pulse is ignored; done at edge 62; valid=1, idx=0, winner_val=1, steps=30.
REQ-036 Scenario: rst_n=0 for one edge while in STEP -> all outputs 0, no done pulse, busy=0; a new run on a=(0,9,0,0) gives idx=1, winner_val=9.
